// File: rtl/alu_req_scheduler.sv
// -----------------------------------------------------------------------------
// alu_req_scheduler
//
// Purpose:
//   Shares a single 64-bit vector ALU among NUM_REQ requesters. Each grant is
//   chosen round-robin, its operands are latched and presented to the ALU, the
//   ALU result is captured on ack and returned to the granted requester with a
//   one-cycle response pulse. Opcode 0 is illegal and is answered immediately
//   with an error response, without touching the ALU.
//
// Optional feature (macro ALU_SCHED_TIMEOUT_EN):
//   When defined, WAIT is bounded: if no ack has arrived after TIMEOUT cycles
//   in WAIT, the op is aborted with rsp_err=1 and rsp_data=0. An ack in the
//   final cycle still wins. When undefined, WAIT lasts until ack.
//
// Ports:
//   clk, rst     - single rising-edge clock, synchronous active-high reset
//   req_valid    - per-requester request, held until accepted
//   req_ready    - one-hot accept pulse (IDLE cycle of the grant)
//   req_a/req_b  - flattened operands, requester i at [i*DATA_W +: DATA_W]
//   req_op       - flattened 3-bit opcodes, requester i at [i*3 +: 3]
//   rsp_valid    - one-hot one-cycle response pulse
//   rsp_data     - result, meaningful while rsp_valid is nonzero
//   rsp_err      - error flag, qualified by rsp_valid
//   busy         - high whenever the scheduler is not IDLE
//   alu_a/alu_b/alu_opcode/alu_en - registered ALU drive, zero outside ISSUE/WAIT
//   alu_y/alu_ack - ALU result and acknowledge
// -----------------------------------------------------------------------------
module alu_req_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int RES_W   = 65,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]      req_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]          rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_opcode,
    output logic                      alu_en,
    input  logic [RES_W-1:0]          alu_y,
    input  logic                      alu_ack
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("alu_req_scheduler: NUM_REQ must be 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("alu_req_scheduler: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Unpacked views of the flattened request buses.
    logic [DATA_W-1:0] a_arr  [NUM_REQ];
    logic [DATA_W-1:0] b_arr  [NUM_REQ];
    logic [2:0]        op_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi]  = req_a[gi*DATA_W +: DATA_W];
        assign b_arr[gi]  = req_b[gi*DATA_W +: DATA_W];
        assign op_arr[gi] = req_op[gi*3 +: 3];
    end

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   gnt_idx_q,    gnt_idx_d;
    logic               err_q,        err_d;
    logic [DATA_W-1:0]  alu_a_q,      alu_a_d;
    logic [DATA_W-1:0]  alu_b_q,      alu_b_d;
    logic [2:0]         alu_op_q,     alu_op_d;
    logic               alu_en_q,     alu_en_d;
    logic [NUM_REQ-1:0] rsp_valid_q,  rsp_valid_d;
    logic [RES_W-1:0]   rsp_data_q,   rsp_data_d;
    logic               rsp_err_q,    rsp_err_d;
    logic               busy_q,       busy_d;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   tmo_cnt_q,    tmo_cnt_d;
`endif

    // Round-robin search: first set request strictly after last_grant, wrapping.
    logic             any_req;
    logic [IDX_W-1:0] arb_idx;

    always_comb begin
        int  cand;
        logic found;
        any_req = |req_valid;
        arb_idx = last_grant_q;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                arb_idx = IDX_W'(cand);
            end
        end
    end

    // Accept pulse is combinational so the requester sees it in the grant cycle.
    // It is masked during reset so every output reads zero while rst is high.
    assign req_ready = (state_q == IDLE && any_req && !rst)
                     ? (NUM_REQ'(1) << arb_idx) : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_idx_d    = gnt_idx_q;
        err_d        = err_q;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_op_d     = 3'd0;
        alu_en_d     = 1'b0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_idx_d = arb_idx;
                    if (op_arr[arb_idx] == 3'd0) begin
                        // Illegal opcode: answer at once, ALU never enabled.
                        err_d      = 1'b1;
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end else begin
                        err_d    = 1'b0;
                        alu_a_d  = a_arr[arb_idx];
                        alu_b_d  = b_arr[arb_idx];
                        alu_op_d = op_arr[arb_idx];
                        alu_en_d = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                alu_a_d  = alu_a_q;
                alu_b_d  = alu_b_q;
                alu_op_d = alu_op_q;
                alu_en_d = 1'b1;
                state_d  = WAIT;
`ifdef ALU_SCHED_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (alu_ack) begin
                    // Full-width pass-through, including any borrow/carry bit.
                    rsp_data_d = alu_y;
                    err_d      = 1'b0;
                    state_d    = RESP;
`ifdef ALU_SCHED_TIMEOUT_EN
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    err_d      = 1'b1;
                    state_d    = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    alu_a_d   = alu_a_q;
                    alu_b_d   = alu_b_q;
                    alu_op_d  = alu_op_q;
                    alu_en_d  = 1'b1;
                end
`else
                end else begin
                    alu_a_d  = alu_a_q;
                    alu_b_d  = alu_b_q;
                    alu_op_d = alu_op_q;
                    alu_en_d = 1'b1;
                end
`endif
            end
            RESP: begin
                last_grant_d = gnt_idx_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response outputs are registered: they are loaded on entry to RESP
        // and therefore valid exactly during the RESP cycle.
        if (state_q != RESP && state_d == RESP) begin
            rsp_valid_d = NUM_REQ'(1) << gnt_idx_d;
            rsp_err_d   = err_d;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            gnt_idx_q    <= '0;
            err_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 3'd0;
            alu_en_q     <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_idx_q    <= gnt_idx_d;
            err_q        <= err_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_en_q     <= alu_en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
`ifdef ALU_SCHED_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign alu_en     = alu_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_req_scheduler
//
// Directed bench for alu_req_scheduler with NUM_REQ=4, DATA_W=64, RES_W=65.
// A behavioural ALU (add / subtract with borrow / xor / and) answers with
// ack = en unless ack_hold is set. Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_req_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int RES_W   = 65;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*3-1:0]      req_op;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [RES_W-1:0]          rsp_data;
    logic                      rsp_err;
    logic                      busy;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [2:0]                alu_opcode;
    logic                      alu_en;
    logic [RES_W-1:0]          alu_y;
    logic                      alu_ack;
    logic                      ack_hold;

    logic [DATA_W-1:0] a_in  [NUM_REQ];
    logic [DATA_W-1:0] b_in  [NUM_REQ];
    logic [2:0]        op_in [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
        assign req_a[gi*DATA_W +: DATA_W] = a_in[gi];
        assign req_b[gi*DATA_W +: DATA_W] = b_in[gi];
        assign req_op[gi*3 +: 3]          = op_in[gi];
    end

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (alu_opcode)
            3'd1:    alu_y = {1'b0, alu_a} + {1'b0, alu_b};
            3'd2:    alu_y = {1'b0, alu_a} - {1'b0, alu_b};
            3'd3:    alu_y = {1'b0, alu_a ^ alu_b};
            default: alu_y = {1'b0, alu_a & alu_b};
        endcase
    end
    assign alu_ack = alu_en & ~ack_hold;

    alu_req_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .RES_W   (RES_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_en     (alu_en),
        .alu_y      (alu_y),
        .alu_ack    (alu_ack)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [RES_W-1:0] got,
                         input logic [RES_W-1:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [2:0] op);
        a_in[idx]  = a;
        b_in[idx]  = b;
        op_in[idx] = op;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Round-robin table: expected grant order and xor results
    int                exp_gnt [5] = '{0, 1, 2, 3, 0};
    logic [RES_W-1:0]  exp_xor [NUM_REQ];

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ack_hold = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, '0, '0, 3'd0);

        // ---------------- reset state ----------------
        do_reset();
        check("rst_req_ready", RES_W'(req_ready), 0);
        check("rst_rsp_valid", RES_W'(rsp_valid), 0);
        check("rst_busy",      RES_W'(busy), 0);
        check("rst_alu_en",    RES_W'(alu_en), 0);
        check("rst_rsp_data",  rsp_data, 0);

        // ---------------- single add: 5 + 3 ----------------
        set_req(0, 64'd5, 64'd3, 3'd1);
        req_valid = 4'b0001;
        #1;
        check("add_ready", RES_W'(req_ready), 65'b0001);
        tick();                                   // T+1: ISSUE
        req_valid = '0;
        check("add_en_issue", RES_W'(alu_en), 1);
        check("add_alu_a",    RES_W'(alu_a), 5);
        check("add_alu_op",   RES_W'(alu_opcode), 1);
        check("add_busy",     RES_W'(busy), 1);
        tick();                                   // T+2: WAIT
        check("add_en_wait",  RES_W'(alu_en), 1);
        check("add_rsp_early", RES_W'(rsp_valid), 0);
        tick();                                   // T+3: RESP
        check("add_rsp_valid", RES_W'(rsp_valid), 65'b0001);
        check("add_rsp_data",  rsp_data, 65'd8);
        check("add_rsp_err",   RES_W'(rsp_err), 0);
        check("add_en_resp",   RES_W'(alu_en), 0);
        tick();                                   // T+4: IDLE
        check("add_rsp_drop", RES_W'(rsp_valid), 0);
        check("add_idle",     RES_W'(busy), 0);

        // ---------------- round robin, all requesting xor ----------------
        do_reset();
        set_req(0, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0F0F, 3'd3);
        set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 3'd3);
        set_req(2, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 3'd3);
        set_req(3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_0000_0000, 3'd3);
        exp_xor[0] = 65'h0_0000_0000_0000_0FF0;
        exp_xor[1] = 65'h0_FFFF_FFFF_FFFF_FFFF;
        exp_xor[2] = 65'h0_FFFF_FFFF_FFFF_FFFF;
        exp_xor[3] = 65'h0_0000_0000_9ABC_DEF0;
        req_valid = 4'b1111;
        #1;
        for (int r = 0; r < 5; r++) begin
            check($sformatf("rr%0d_ready", r), RES_W'(req_ready),
                  RES_W'(1) << exp_gnt[r]);
            tick();                               // ISSUE
            check($sformatf("rr%0d_no_ready", r), RES_W'(req_ready), 0);
            tick();                               // WAIT
            tick();                               // RESP
            check($sformatf("rr%0d_rsp_valid", r), RES_W'(rsp_valid),
                  RES_W'(1) << exp_gnt[r]);
            check($sformatf("rr%0d_rsp_data", r), rsp_data, exp_xor[exp_gnt[r]]);
            tick();                               // IDLE, next grant
        end
        req_valid = '0;
        tick();

        // ---------------- subtract with borrow, requester 2 ----------------
        set_req(2, 64'd0, 64'd1, 3'd2);
        req_valid = 4'b0100;
        #1;
        check("sub_ready", RES_W'(req_ready), 65'b0100);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("sub_rsp_valid", RES_W'(rsp_valid), 65'b0100);
        check("sub_rsp_data",  rsp_data, 65'h1_FFFF_FFFF_FFFF_FFFF);
        check("sub_rsp_err",   RES_W'(rsp_err), 0);
        tick();

        // ---------------- illegal opcode 0, requester 2 ----------------
        set_req(2, 64'd7, 64'd9, 3'd0);
        req_valid = 4'b0100;
        #1;
        check("op0_ready", RES_W'(req_ready), 65'b0100);
        tick();                                   // RESP one cycle after accept
        req_valid = '0;
        check("op0_rsp_valid", RES_W'(rsp_valid), 65'b0100);
        check("op0_rsp_err",   RES_W'(rsp_err), 1);
        check("op0_rsp_data",  rsp_data, 0);
        check("op0_alu_en",    RES_W'(alu_en), 0);
        tick();
        check("op0_idle",      RES_W'(busy), 0);
        check("op0_alu_en2",   RES_W'(alu_en), 0);

        // ---------------- reset during WAIT ----------------
        set_req(0, 64'd1, 64'd1, 3'd1);
        req_valid = 4'b0001;                      // leaves last_grant = 0
        tick(); req_valid = '0; tick(); tick();
        check("pre_rsp_data", rsp_data, 65'd2);
        tick();
        set_req(3, 64'd4, 64'd4, 3'd1);
        ack_hold  = 1'b1;
        req_valid = 4'b1000;
        #1;
        check("wr_ready3", RES_W'(req_ready), 65'b1000);
        tick(); req_valid = '0; tick(); tick();   // in WAIT
        check("wr_wait_en", RES_W'(alu_en), 1);
        rst       = 1'b1;
        req_valid = 4'b1001;
        tick();
        check("wr_ready",     RES_W'(req_ready), 0);
        check("wr_rsp_valid", RES_W'(rsp_valid), 0);
        check("wr_busy",      RES_W'(busy), 0);
        check("wr_alu_en",    RES_W'(alu_en), 0);
        check("wr_alu_a",     RES_W'(alu_a), 0);
        check("wr_alu_op",    RES_W'(alu_opcode), 0);
        check("wr_rsp_data",  rsp_data, 0);
        ack_hold = 1'b0;
        rst      = 1'b0;
        #1;
        check("wr_ready_after", RES_W'(req_ready), 65'b0001);
        tick(); req_valid = '0; tick(); tick();
        check("wr_rsp_valid0", RES_W'(rsp_valid), 65'b0001);
        check("wr_rsp_data0",  rsp_data, 65'd2);
        tick();

        // ---------------- stalled ack ----------------
        set_req(1, 64'd10, 64'd20, 3'd1);
        ack_hold  = 1'b1;
        req_valid = 4'b0010;
        tick(); req_valid = '0;                   // ISSUE
        tick();                                   // WAIT entry
`ifdef ALU_SCHED_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("tmo_no_rsp_yet", RES_W'(rsp_valid), 0);
        check("tmo_busy_wait",  RES_W'(busy), 1);
        tick();                                   // 16 cycles after WAIT entry
        check("tmo_rsp_valid", RES_W'(rsp_valid), 65'b0010);
        check("tmo_rsp_err",   RES_W'(rsp_err), 1);
        check("tmo_rsp_data",  rsp_data, 0);
        check("tmo_busy_resp", RES_W'(busy), 1);
        tick();
        check("tmo_busy_drop", RES_W'(busy), 0);
        ack_hold = 1'b0;
`else
        for (int i = 0; i < 20; i++) tick();
        check("stall_busy",  RES_W'(busy), 1);
        check("stall_en",    RES_W'(alu_en), 1);
        check("stall_alu_b", RES_W'(alu_b), 20);
        check("stall_no_rsp", RES_W'(rsp_valid), 0);
        ack_hold = 1'b0;
        tick();
        check("stall_rsp_valid", RES_W'(rsp_valid), 65'b0010);
        check("stall_rsp_data",  rsp_data, 65'd30);
        check("stall_rsp_err",   RES_W'(rsp_err), 0);
        tick();
        check("stall_idle", RES_W'(busy), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one 64-bit vector ALU instance among NUM_REQ requesters using round-robin arbitration.
- Accepts one operation at a time, latches its operands and drives the ALU's a/b/en/opcode inputs.
- Waits for the ALU ack, captures the 65-bit result and returns it to the granted requester with a one-cycle response pulse.
- Sits between the instruction-issue logic and the ALU in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 64, operand width.
- RES_W, 65, result width (ALU y width).
- TIMEOUT, 16, cycles to wait for ack before aborting; used only when ALU_SCHED_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request; held until accepted.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_a  in  NUM_REQ*DATA_W  flattened operand A; requester i uses slice [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  flattened operand B, same slicing.
- req_op  in  NUM_REQ*3  flattened 3-bit opcode; valid opcodes are 1..7.
- rsp_valid  out  NUM_REQ  one-hot one-cycle response pulse.
- rsp_data  out  RES_W  result; valid only while rsp_valid is nonzero.
- rsp_err  out  1  error flag qualified by rsp_valid.
- busy  out  1  high whenever state != IDLE.
- alu_a, alu_b  out  DATA_W  registered operands to the ALU.
- alu_opcode  out  3  registered opcode to the ALU.
- alu_en  out  1  ALU enable.
- alu_y  in  RES_W  ALU result.
- alu_ack  in  1  ALU acknowledge.

Behaviour:
- Reset: synchronous, active-high, single clock; rst overrides everything, including mid-operation.
  - State returns to IDLE; any in-flight op is dropped with no response.
  - All outputs go to 0.
  - Round-robin pointer last_grant is set to NUM_REQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching upward from last_grant+1, with wrap-around.
  - Assert req_ready[g] for this cycle only.
  - Latch req_a/req_b/req_op slices of g plus the index g.
  - If opcode == 0, set err_latched and go to RESP; otherwise go to ISSUE.
  - No valid requests: remain in IDLE.
- ISSUE: drive alu_a/alu_b/alu_opcode from the latch, assert alu_en=1, go to WAIT.
- WAIT:
  - alu_en and operands held stable.
  - On alu_ack=1, capture alu_y into rsp_data, clear err, go to RESP.
  - alu_ack=0: stay in WAIT.
- RESP:
  - rsp_valid[g]=1 and rsp_err driven for exactly one cycle.
  - alu_en=0; last_grant <= g; go to IDLE.
  - rsp_data holds its value afterwards but is meaningful only while rsp_valid is nonzero.
- Latency with a combinational ALU (ack=en): accept at cycle T, alu_en rises T+1, capture T+2, rsp_valid T+3.
- Throughput: one op per 4 cycles. No back-to-back accept; the next grant occurs in the IDLE cycle after RESP.
- Simultaneous events:
  - Requests arriving during busy wait in IDLE arbitration.
  - A requester may raise req_valid again in its own RESP cycle; it becomes lowest priority next round.
- Width rules:
  - Result is passed through unmodified at the full 65 bits.
  - Opcode 2 borrow appears in bit 64 exactly as the ALU produces it.
- Outputs outside ISSUE/WAIT: alu_a, alu_b, alu_opcode, alu_en are all 0.

Optional Feature:
- ALU_SCHED_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT-1 without ack, go to RESP with rsp_err=1 and rsp_data=0.
  - An ack arriving in that same cycle takes priority and completes normally.
- Not defined: no counter; WAIT lasts indefinitely until ack.

Test Plan:
- Reset, then req_valid=4'b0001, a=5, b=3, op=1 -> req_ready[0] same cycle; rsp_valid[0] three cycles later; rsp_data=8, rsp_err=0.
- req_valid=4'b1111 held continuously, all op=3 -> grant order 0,1,2,3,0 with responses 4 cycles apart; each rsp_data = a_i ^ b_i.
- Requester 2 alone, a=0, b=1, op=2 -> rsp_data = 65'h1_FFFF_FFFF_FFFF_FFFF, rsp_valid[2]. Then op=0 -> rsp_err=1, rsp_data=0, 1 cycle after accept, with alu_en never asserted.
- rst pulsed during WAIT -> no rsp_valid; all outputs 0 next cycle; after release, a pending request from requester 0 is granted before requester 3.
- With ALU_SCHED_TIMEOUT_EN defined, TIMEOUT=16, alu_ack tied 0 -> rsp_err=1 exactly 16 cycles after entering WAIT; busy drops the following cycle.
